vigenere_key_scheduler: RTL

Sequential key-stream stage directly upstream of the combinational Vigenère encryptor. It stores a key of up to KEY_MAX_LEN characters. For every message character accepted, it presents that character together with the correctly repeating key character, so the pair can feed the encryptor's message_char/key_char inputs. Valid/ready handshakes are used on the key-load, message-in and pair-out sides.

---
 rtl/vigenere_key_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vigenere_key_scheduler.sv
// vigenere_key_scheduler: stores a key of up to KEY_MAX_LEN characters and pairs every
// accepted message character with the cyclically repeating key character for the
// downstream Vigenere encryptor. Valid/ready handshakes on key-load, message and pair sides.
// Optional feature: define VIG_RANGE_CHECK_EN to flag accepted bytes outside '*'..'Z'
// on the sticky range_err output; otherwise range_err is tied low.
module vigenere_key_scheduler #(
   parameter int KEY_MAX_LEN = 16,
   localparam int IDX_W = (KEY_MAX_LEN > 1) ? $clog2(KEY_MAX_LEN) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_in_valid,
   input  logic [7:0]       key_in_char,
   input  logic             key_in_last,
   output logic             key_in_ready,
   input  logic             key_clear,
   input  logic             msg_restart,
   input  logic             msg_in_valid,
   input  logic [7:0]       msg_in_char,
   output logic             msg_in_ready,
   output logic             out_valid,
   output logic [7:0]       out_msg_char,
   output logic [7:0]       out_key_char,
   input  logic             out_ready,
   output logic [IDX_W:0]   key_len,
   output logic             range_err
);

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [IDX_W:0] C_MAX_LEN = (IDX_W+1)'(KEY_MAX_LEN);

   state_t           r_state;
   logic [IDX_W:0]   r_key_len;
   logic [IDX_W-1:0] r_idx;
   logic [7:0]       r_key_mem [KEY_MAX_LEN];
   logic             r_out_valid;
   logic [7:0]       r_out_msg;
   logic [7:0]       r_out_key;

   logic             w_key_acc;
   logic             w_msg_acc;
   logic             w_key_wr;
   logic [IDX_W:0]   w_len_p1;
   logic [IDX_W:0]   w_len_m1;
   logic [IDX_W-1:0] w_idx_use;
   logic [IDX_W-1:0] w_idx_next;

   assign key_in_ready = (r_state == LOAD);
   assign msg_in_ready = (r_state == RUN) && (!r_out_valid || out_ready);

   assign w_key_acc = key_in_valid && key_in_ready;
   assign w_msg_acc = msg_in_valid && msg_in_ready;
   // key_clear wins over a key byte offered in the same cycle
   assign w_key_wr  = w_key_acc && !key_clear;
   assign w_len_p1  = r_key_len + (IDX_W+1)'(1);
   assign w_len_m1  = r_key_len - (IDX_W+1)'(1);

   // Index used by this cycle's message (restart forces 0) and its wrapped successor
   always_comb begin
      w_idx_use  = (msg_restart && (r_state == RUN)) ? '0 : r_idx;
      w_idx_next = ({1'b0, w_idx_use} == w_len_m1) ? '0 : (w_idx_use + IDX_W'(1));
   end

   // Key storage: not reset, only key_len decides which entries are meaningful
   always_ff @(posedge clk) begin
      if (w_key_wr) begin
         r_key_mem[r_key_len[IDX_W-1:0]] <= key_in_char;
      end
   end

   // Control FSM plus registered pair output; key_clear keeps a pending pair until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= LOAD;
         r_key_len   <= '0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_msg   <= '0;
         r_out_key   <= '0;
      end else begin
         if (w_msg_acc) begin
            r_out_msg   <= msg_in_char;
            r_out_key   <= r_key_mem[w_idx_use];
            r_out_valid <= 1'b1;
            r_idx       <= w_idx_next;
         end else begin
            if (out_ready) begin
               r_out_valid <= 1'b0;
            end
            if (msg_restart && (r_state == RUN)) begin
               r_idx <= '0;
            end
         end

         if (key_clear) begin
            r_state   <= LOAD;
            r_key_len <= '0;
            r_idx     <= '0;
         end else if (w_key_acc) begin
            r_key_len <= w_len_p1;
            // filling the buffer acts as an implicit last byte
            if (key_in_last || (w_len_p1 == C_MAX_LEN)) begin
               r_state <= RUN;
            end
         end
      end
   end

`ifdef VIG_RANGE_CHECK_EN
   logic r_range_err;
   logic w_bad_key;
   logic w_bad_msg;

   assign w_bad_key = w_key_wr && ((key_in_char < 8'h2A) || (key_in_char > 8'h5A));
   assign w_bad_msg = w_msg_acc && ((msg_in_char < 8'h2A) || (msg_in_char > 8'h5A));

   // Sticky out-of-range flag, cleared only by key_clear or reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_range_err <= 1'b0;
      end else if (key_clear) begin
         r_range_err <= 1'b0;
      end else if (w_bad_key || w_bad_msg) begin
         r_range_err <= 1'b1;
      end
   end

   assign range_err = r_range_err;
`else
   assign range_err = 1'b0;
`endif

   assign out_valid    = r_out_valid;
   assign out_msg_char = r_out_msg;
   assign out_key_char = r_out_key;
   assign key_len      = r_key_len;

endmodule
